input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
- SENSOR_MIN_CYCLES, 4, consecutive high cycles of traffic_sensor_debounce required before sensor_active asserts; legal range 1..2^SENSOR_CNT_W-1.
- SENSOR_CNT_W, 4, width of the sensor qualification counter.

REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  input  1  single system clock; all state changes on its rising edge.
- global_reset  input  1  asynchronous, active-high reset.
- walk_request_debounce  input  1  clean pedestrian button level.
- reprogram_debounce  input  1  clean reprogram button level.
- traffic_sensor_debounce  input  1  clean vehicle sensor level.
- walk_ack  input  1  one-cycle acknowledge from the traffic FSM that it has served the pending walk request.
- walk_pending  output  1  sticky walk request flag.
- reprogram_pulse  output  1  one-cycle pulse per reprogram press.
- sensor_active  output  1  qualified vehicle-present level.
- walk_count  output  8  saturating count of walk presses; present only with WALK_COUNT_EN.

Function
REQ-003 The block SHALL register the previous value of walk_request_debounce and of reprogram_debounce, and SHALL detect a rising edge as current=1 and previous=0.
REQ-004 Each edge-detect history register SHALL reset to 1, so that an input already high at reset release produces no event until it goes low and rises again.
REQ-005 All outputs SHALL be registered; an input rising edge sampled at clock edge N SHALL be visible on the output after clock edge N, with one cycle of latency.
REQ-006 reprogram_pulse SHALL be high for exactly one cycle per rising edge of reprogram_debounce, regardless of how long the input stays high.
REQ-007 walk_pending SHALL set on a walk rising edge and SHALL stay set until a cycle in which walk_ack=1.
REQ-008 If walk_ack=1 and a walk rising edge occur in the same cycle, walk_pending SHALL be 1 afterwards (the new request wins).
REQ-009 walk_ack=1 while walk_pending=0 SHALL have no effect.
REQ-010 Additional walk rising edges while walk_pending=1 SHALL leave it at 1, with no queuing.
REQ-011 The sensor counter SHALL behave as follows:
- While traffic_sensor_debounce=1, it increments each cycle and saturates at SENSOR_MIN_CYCLES.
- A cycle with traffic_sensor_debounce=0 clears it to 0.
REQ-012 sensor_active SHALL be 1 exactly when the registered counter value equals SENSOR_MIN_CYCLES. As a result, it first rises SENSOR_MIN_CYCLES cycles after the input rises and falls one cycle after the input falls.
REQ-013 A low glitch of one cycle on traffic_sensor_debounce SHALL restart qualification from 0.

Reset
REQ-014 While global_reset=1, the block SHALL asynchronously force walk_pending=0, reprogram_pulse=0, sensor_active=0, sensor counter=0 and walk_count=0, and SHALL force both edge-detect history registers to 1.
REQ-015 Reset asserted mid-operation SHALL discard any pending walk request and any partial sensor qualification; after release, operation SHALL resume per REQ-004.

Configuration
REQ-016 With macro INPUT_CONDITIONER_WALK_COUNT_EN defined, the block SHALL provide the walk_count port:
- It increments by 1 on every walk rising edge, whether or not a request is already pending.
- It saturates at 255.
- It clears only on reset.
REQ-017 Without INPUT_CONDITIONER_WALK_COUNT_EN, the block SHALL omit the walk_count port and its counter logic, and all other behaviour SHALL be identical.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Reset release with walk_request_debounce=1 and reprogram_debounce=1 -> walk_pending=0 and reprogram_pulse=0 for 10 cycles; drive both low for 1 cycle, then high -> walk_pending=1 and one reprogram_pulse one cycle later.
- reprogram_debounce high for 20 cycles -> reprogram_pulse high for exactly 1 cycle.
- Walk edge at cycle 5, walk_ack at cycle 12 -> walk_pending=1 for cycles 6..12 and 0 from cycle 13; walk_ack coincident with a new walk edge -> walk_pending stays 1.
- SENSOR_MIN_CYCLES=4: sensor high 3 cycles, low 1, high 6 -> sensor_active=0 throughout the first burst, then rises after the 4th consecutive high cycle of the second burst and falls 1 cycle after the input falls.
- With INPUT_CONDITIONER_WALK_COUNT_EN: 300 walk edges -> walk_count=255; without the macro -> the module elaborates with no walk_count port.
- global_reset pulsed while walk_pending=1 and the sensor counter is at 2 -> all outputs 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/input_conditioner.sv
// input_conditioner
// Turns the clean (already debounced) button and sensor levels into the
// events the traffic controller consumes:
//   - walk_pending    : sticky pedestrian request, cleared by walk_ack
//   - reprogram_pulse : single-cycle pulse per reprogram press
//   - sensor_active   : vehicle presence, qualified over SENSOR_MIN_CYCLES
// Optional feature: define INPUT_CONDITIONER_WALK_COUNT_EN to add the
// saturating 8-bit walk_count output and its counter.
// Every output comes straight from a flop. Reset is asynchronous, active-high.

module input_conditioner #(
    parameter int SENSOR_MIN_CYCLES = 4,
    parameter int SENSOR_CNT_W      = 4
) (
    input  logic       clk,
    input  logic       global_reset,
    input  logic       walk_request_debounce,
    input  logic       reprogram_debounce,
    input  logic       traffic_sensor_debounce,
    input  logic       walk_ack,
    output logic       walk_pending,
    output logic       reprogram_pulse,
    output logic       sensor_active
`ifdef INPUT_CONDITIONER_WALK_COUNT_EN
    ,
    output logic [7:0] walk_count
`endif
);

    localparam logic [SENSOR_CNT_W-1:0] SensorMin = SENSOR_CNT_W'(SENSOR_MIN_CYCLES);
    localparam logic [SENSOR_CNT_W-1:0] SensorOne = SENSOR_CNT_W'(1);

    logic                    walkPrev_q;
    logic                    reprogPrev_q;
    logic                    walkPending_q;
    logic                    walkPending_d;
    logic                    reprogPulse_q;
    logic                    reprogPulse_d;
    logic [SENSOR_CNT_W-1:0] sensorCnt_q;
    logic [SENSOR_CNT_W-1:0] sensorCnt_d;
    logic                    sensorActive_q;
    logic                    sensorActive_d;
    logic                    walkRise;
    logic                    reprogRise;

    // History registers power up high so a button already held at reset
    // release is ignored until it is released and pressed again.
    always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) begin
            walkPrev_q   <= 1'b1;
            reprogPrev_q <= 1'b1;
        end else begin
            walkPrev_q   <= walk_request_debounce;
            reprogPrev_q <= reprogram_debounce;
        end
    end

    assign walkRise   = walk_request_debounce & ~walkPrev_q;
    assign reprogRise = reprogram_debounce & ~reprogPrev_q;

    // Next-state for the request flag, the pulse and the qualification
    // counter; a fresh walk edge beats a simultaneous acknowledge.
    always_comb begin
        walkPending_d = walkRise | (walkPending_q & ~walk_ack);
        reprogPulse_d = reprogRise;
        sensorCnt_d   = '0;
        if (traffic_sensor_debounce) begin
            if (sensorCnt_q == SensorMin) begin
                sensorCnt_d = sensorCnt_q;
            end else begin
                sensorCnt_d = sensorCnt_q + SensorOne;
            end
        end
        sensorActive_d = (sensorCnt_d == SensorMin);
    end

    // Output and counter state; sensorActive_q always mirrors
    // (sensorCnt_q == SENSOR_MIN_CYCLES) but comes from its own flop.
    always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) begin
            walkPending_q  <= 1'b0;
            reprogPulse_q  <= 1'b0;
            sensorCnt_q    <= '0;
            sensorActive_q <= 1'b0;
        end else begin
            walkPending_q  <= walkPending_d;
            reprogPulse_q  <= reprogPulse_d;
            sensorCnt_q    <= sensorCnt_d;
            sensorActive_q <= sensorActive_d;
        end
    end

    assign walk_pending    = walkPending_q;
    assign reprogram_pulse = reprogPulse_q;
    assign sensor_active   = sensorActive_q;

`ifdef INPUT_CONDITIONER_WALK_COUNT_EN
    logic [7:0] walkCount_q;
    logic [7:0] walkCount_d;

    // Every walk press counts, pending or not, sticking at 255.
    always_comb begin
        walkCount_d = walkCount_q;
        if (walkRise && (walkCount_q != 8'hFF)) begin
            walkCount_d = walkCount_q + 8'd1;
        end
    end

    // Press counter register; only reset clears it.
    always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) begin
            walkCount_q <= 8'd0;
        end else begin
            walkCount_q <= walkCount_d;
        end
    end

    assign walk_count = walkCount_q;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner (default SENSOR_MIN_CYCLES = 4).
// The walk_count checks are built only when INPUT_CONDITIONER_WALK_COUNT_EN
// is defined; otherwise the DUT is instantiated without that port.

module tb_input_conditioner;

    logic       clk;
    logic       globalReset;
    logic       walkReq;
    logic       reprog;
    logic       sensor;
    logic       walkAck;
    logic       walkPending;
    logic       reprogPulse;
    logic       sensorActive;
`ifdef INPUT_CONDITIONER_WALK_COUNT_EN
    logic [7:0] walkCount;
`endif

    int testCount;
    int failCount;

    input_conditioner #(
        .SENSOR_MIN_CYCLES (4),
        .SENSOR_CNT_W      (4)
    ) dut (
        .clk                     (clk),
        .global_reset            (globalReset),
        .walk_request_debounce   (walkReq),
        .reprogram_debounce      (reprog),
        .traffic_sensor_debounce (sensor),
        .walk_ack                (walkAck),
        .walk_pending            (walkPending),
        .reprogram_pulse         (reprogPulse),
        .sensor_active           (sensorActive)
`ifdef INPUT_CONDITIONER_WALK_COUNT_EN
        ,
        .walk_count              (walkCount)
`endif
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock edge, then settle 1 unit so sampling is off the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive all functional inputs, then let one clock edge sample them.
    task automatic applyStimulus(input logic w, input logic r, input logic s, input logic a);
        walkReq = w;
        reprog  = r;
        sensor  = s;
        walkAck = a;
        tick();
    endtask

    // One comparison against a hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        testCount   = 0;
        failCount   = 0;
        globalReset = 1'b1;
        walkReq     = 1'b1;
        reprog      = 1'b1;
        sensor      = 1'b0;
        walkAck     = 1'b0;

        // Reset held with both buttons high.
        #3;
        checkOutput("rst_walk_pending", {7'd0, walkPending}, 8'd0);
        checkOutput("rst_reprog_pulse", {7'd0, reprogPulse}, 8'd0);
        checkOutput("rst_sensor_active", {7'd0, sensorActive}, 8'd0);
`ifdef INPUT_CONDITIONER_WALK_COUNT_EN
        checkOutput("rst_walk_count", walkCount, 8'd0);
`endif
        tick();
        globalReset = 1'b0;

        // Buttons high through release: no events for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            checkOutput("held_walk_pending", {7'd0, walkPending}, 8'd0);
            checkOutput("held_reprog_pulse", {7'd0, reprogPulse}, 8'd0);
        end

        // Low for one cycle, then high: both events one cycle later.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("low_walk_pending", {7'd0, walkPending}, 8'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("rearm_walk_pending", {7'd0, walkPending}, 8'd1);
        checkOutput("rearm_reprog_pulse", {7'd0, reprogPulse}, 8'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("rearm_pulse_drop", {7'd0, reprogPulse}, 8'd0);
        checkOutput("rearm_walk_sticky", {7'd0, walkPending}, 8'd1);

        // Clear the request; ack is honoured.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("ack_clear", {7'd0, walkPending}, 8'd0);

        // Reprogram held high for 20 cycles: exactly one pulse.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("long_press_pulse", {7'd0, reprogPulse}, 8'd1);
        for (int i = 0; i < 19; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            checkOutput("long_press_no_repeat", {7'd0, reprogPulse}, 8'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("release_no_pulse", {7'd0, reprogPulse}, 8'd0);

        // Walk edge sampled at edge 5, ack at edge 12.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("walk_set_c6", {7'd0, walkPending}, 8'd1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("walk_hold_c7_12", {7'd0, walkPending}, 8'd1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("walk_cleared_c13", {7'd0, walkPending}, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("walk_stays_clear", {7'd0, walkPending}, 8'd0);

        // Ack while idle has no effect.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("idle_ack", {7'd0, walkPending}, 8'd0);

        // Ack coincident with a new edge: the request wins.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("ack_vs_edge", {7'd0, walkPending}, 8'd1);

        // Further edges while pending leave it set; then clear it.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("second_edge_pending", {7'd0, walkPending}, 8'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("second_ack_clear", {7'd0, walkPending}, 8'd0);

        // Sensor: high 3, low 1, high 6, low.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
            checkOutput("sensor_burst1", {7'd0, sensorActive}, 8'd0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("sensor_glitch", {7'd0, sensorActive}, 8'd0);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
            checkOutput("sensor_burst2", {7'd0, sensorActive}, (i >= 4) ? 8'd1 : 8'd0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("sensor_fall", {7'd0, sensorActive}, 8'd0);

        // Build state: walk pending, sensor count 2, a reprogram pulse.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("pre_rst_walk", {7'd0, walkPending}, 8'd1);
        checkOutput("pre_rst_pulse", {7'd0, reprogPulse}, 8'd1);

        // Asynchronous reset between edges clears outputs at once.
        #2;
        globalReset = 1'b1;
        #1;
        checkOutput("async_rst_walk", {7'd0, walkPending}, 8'd0);
        checkOutput("async_rst_pulse", {7'd0, reprogPulse}, 8'd0);
        checkOutput("async_rst_sensor", {7'd0, sensorActive}, 8'd0);
        #1;
        globalReset = 1'b0;

        // After release the sensor qualifies from zero; held buttons stay quiet.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
            checkOutput("post_rst_sensor", {7'd0, sensorActive}, (i == 4) ? 8'd1 : 8'd0);
            checkOutput("post_rst_walk", {7'd0, walkPending}, 8'd0);
            checkOutput("post_rst_pulse", {7'd0, reprogPulse}, 8'd0);
        end

`ifdef INPUT_CONDITIONER_WALK_COUNT_EN
        // Fresh reset, then 300 walk edges: count saturates at 255.
        globalReset = 1'b1;
        #1;
        checkOutput("cnt_rst", walkCount, 8'd0);
        globalReset = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 1 || i == 2 || i == 254 || i == 255 || i == 256 || i == 300) begin
                checkOutput("walk_count", walkCount, (i < 255) ? 8'(i) : 8'd255);
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
